cog_vcap: RTL and testbench
===========================

COG_VCAP -- requirements
Module: cog_vcap

Interface
REQ-001 clk_cog  input  1  cog clock; single clock domain; all state on its rising edge.
REQ-002 nres  input  1  asynchronous active-low reset.
REQ-003 setcfg  input  1  load data into capture configuration register cfg.
REQ-004 setscl  input  1  load data[19:0] into scale register scl.
REQ-005 data  input  32  configuration/scale write data.
REQ-006 pin_in  input  32  sampled pin levels, already synchronised to clk_cog.
REQ-007 palette  input  32  four 8-bit colour codes; entry k = palette[8k+7:8k].
REQ-008 rdack  input  1  cog consumes word_out this cycle; ignored when valid=0.
REQ-009 word_out  output  32  last completed captured pixel word.
REQ-010 valid  output  1  word_out holds an unread word.
REQ-011 ovf  output  1  sticky: a completed word overwrote an unread word.
REQ-012 miss  output  1  sticky: a sample matched no palette entry.

Function
REQ-013 cfg fields: [30:29] enable (nonzero = run); [28] mode (1 = 2-bit pixels, 0 = 1-bit); [10:9] byte group; [7:0] pin mask.
REQ-014 scl fields: [19:12] clocks per pixel; [11:0] clocks per word; value 0 means 256 or 4096, respectively.
REQ-015 States: IDLE (enable=0), RUN (enable!=0); the IDLE->RUN edge loads cnt<=scl[19:12] and set<=scl[11:0], with the shift register cleared.
REQ-016 In RUN, each cycle: cnt reloads from scl[19:12] when cnt==1, else decrements; set reloads from scl[11:0] when set==1, else decrements; 8-bit/12-bit wrap from 0 is natural.
REQ-017 Sample strobe = (cnt==1) in RUN; sample byte s = (pin_in >> {group,3'b000})[7:0] & mask.
REQ-018 Index = lowest k with (palette entry k & mask) == s; no match -> index 0 and miss<=1.
REQ-019 On strobe: mode=1 shifts pix <= {idx[1:0], pix[31:2]}; mode=0 shifts pix <= {idx[0], pix[31:1]}; first sampled pixel ends in the LSBs after 16/32 samples.
REQ-020 Word end = (set==1) in RUN; if a strobe coincides, word_out gets the shifted value including that sample; else word_out <= pix; pix is cleared the same cycle.
REQ-021 Word end with valid=1 and rdack=0: word_out overwritten, ovf<=1, valid stays 1.
REQ-022 Word end with rdack=1 in the same cycle: new word loaded, valid stays 1, no ovf.
REQ-023 rdack=1 without word end: valid<=0 next cycle; word_out unchanged.
REQ-024 Latency: word_out/valid update on the clock edge at which set==1 is observed (visible the next cycle).
REQ-025 setcfg with data[30:29]=0 -> IDLE next cycle; counters hold, partial word discarded, word_out/valid retained.
REQ-026 setscl during RUN takes effect only at the next reload of each counter.
REQ-027 ovf and miss clear only on setcfg or reset.

Reset
REQ-028 nres low asynchronously forces: cfg=0, scl=0, cnt=0, set=0, pix=0, word_out=0, valid=0, ovf=0, miss=0, state IDLE.
REQ-029 Reset mid-word discards all partial state; first word after release follows REQ-015 anew.

Structure
REQ-030 Shared package holds cfg/scl field positions, mode encodings and state enumeration.
REQ-031 One sub-module, cog_vcap_match: combinational palette/mask comparator returning idx and hit.

Verification
REQ-032 scl={8'd1,12'd16}, mode=1, mask=FF, group=0, palette=03_02_01_00, pin_in[7:0] cycling 00,01,02,03 -> word_out=E4E4E4E4, valid rises 16 clocks after enable.
REQ-033 mode=0, scl={8'd2,12'd64}, pin_in toggles 00/01 every 2 clocks -> word_out=AAAAAAAA after 64 clocks.
REQ-034 Two word ends with rdack held 0 -> ovf=1, valid=1, word_out = second word; setcfg clears ovf.
REQ-035 rdack asserted on the exact word-end cycle -> valid stays 1, ovf stays 0, new word present.
REQ-036 pin_in byte=55 not in palette -> miss=1, index 0 shifted in; mask=0F with palette entry 1=F5 -> match idx 1, miss stays 0.
REQ-037 nres pulsed low mid-word -> all outputs 0 immediately; after release, the first word matches a clean-start capture.

Source files
------------

// File: rtl/cog_vcap_pkg.sv
// rtl/cog_vcap_pkg.sv - cog video-capture shared field positions, encodings and states
package cog_vcap_pkg;

    localparam int CFG_EN_HI   = 30;
    localparam int CFG_EN_LO   = 29;
    localparam int CFG_MODE    = 28;
    localparam int CFG_GRP_HI  = 10;
    localparam int CFG_GRP_LO  = 9;
    localparam int CFG_MASK_HI = 7;
    localparam int CFG_MASK_LO = 0;

    localparam int SCL_PIX_HI  = 19;
    localparam int SCL_PIX_LO  = 12;
    localparam int SCL_WORD_HI = 11;
    localparam int SCL_WORD_LO = 0;

    typedef enum logic {
        MODE_1BIT = 1'b0,
        MODE_2BIT = 1'b1
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/cog_vcap_match.sv
// rtl/cog_vcap_match.sv - combinational palette/mask comparator returning lowest matching index
module cog_vcap_match
    import cog_vcap_pkg::*;
(
    input  logic [31:0] palette,
    input  logic [7:0]  mask,
    input  logic [7:0]  sample,
    output logic [1:0]  idx,
    output logic        hit
);

    // Scan from the top entry down so the lowest matching entry wins.
    always_comb begin
        idx = 2'd0;
        hit = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if ((palette[8*k +: 8] & mask) == sample) begin
                idx = 2'(k);
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cog_vcap.sv
// rtl/cog_vcap.sv - cog video capture: samples a masked pin byte, palette-matches and packs pixel words
module cog_vcap
    import cog_vcap_pkg::*;
(
    input  logic        clk_cog,
    input  logic        nres,
    input  logic        setcfg,
    input  logic        setscl,
    input  logic [31:0] data,
    input  logic [31:0] pin_in,
    input  logic [31:0] palette,
    input  logic        rdack,
    output logic [31:0] word_out,
    output logic        valid,
    output logic        ovf,
    output logic        miss
);

    logic [1:0]  cfg_en;
    mode_e       cfg_mode;
    logic [1:0]  cfg_grp;
    logic [7:0]  cfg_mask;
    logic [19:0] scl;
    logic [7:0]  cnt;
    logic [11:0] set;
    logic [31:0] pix;
    state_e      state;

    logic        en_next;
    logic [7:0]  pin_byte;
    logic [7:0]  sample;
    logic [1:0]  idx;
    logic        hit;
    logic        strobe;
    logic        word_end;
    logic [31:0] pix_shift;
    logic [31:0] pix_cap;
    logic        unused_data;

    assign unused_data = ^{data[31], data[27:20]};

    // A disabling setcfg must drop to IDLE at the same edge it is written.
    assign en_next  = setcfg ? (data[CFG_EN_HI:CFG_EN_LO] != 2'd0) : (cfg_en != 2'd0);

    assign pin_byte = pin_in[{cfg_grp, 3'b000} +: 8];
    assign sample   = pin_byte & cfg_mask;

    cog_vcap_match u_match (
        .palette (palette),
        .mask    (cfg_mask),
        .sample  (sample),
        .idx     (idx),
        .hit     (hit)
    );

    assign strobe    = (state == ST_RUN) && (cnt == 8'd1);
    assign word_end  = (state == ST_RUN) && (set == 12'd1);
    assign pix_shift = (cfg_mode == MODE_2BIT) ? {idx, pix[31:2]} : {idx[0], pix[31:1]};
    assign pix_cap   = strobe ? pix_shift : pix;

    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            cfg_en   <= 2'd0;
            cfg_mode <= MODE_1BIT;
            cfg_grp  <= 2'd0;
            cfg_mask <= 8'd0;
            scl      <= 20'd0;
            cnt      <= 8'd0;
            set      <= 12'd0;
            pix      <= 32'd0;
            word_out <= 32'd0;
            valid    <= 1'b0;
            ovf      <= 1'b0;
            miss     <= 1'b0;
            state    <= ST_IDLE;
        end else begin
            if (setcfg) begin
                cfg_en   <= data[CFG_EN_HI:CFG_EN_LO];
                cfg_mode <= mode_e'(data[CFG_MODE]);
                cfg_grp  <= data[CFG_GRP_HI:CFG_GRP_LO];
                cfg_mask <= data[CFG_MASK_HI:CFG_MASK_LO];
            end
            if (setscl) begin
                scl <= data[19:0];
            end

            if (valid && rdack) begin
                valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (en_next) begin
                        state <= ST_RUN;
                        cnt   <= scl[SCL_PIX_HI:SCL_PIX_LO];
                        set   <= scl[SCL_WORD_HI:SCL_WORD_LO];
                        pix   <= 32'd0;
                    end
                end
                ST_RUN: begin
                    if (!en_next) begin
                        // Counters hold; partial word is dropped.
                        state <= ST_IDLE;
                        pix   <= 32'd0;
                    end else begin
                        cnt <= (cnt == 8'd1)  ? scl[SCL_PIX_HI:SCL_PIX_LO]   : cnt - 8'd1;
                        set <= (set == 12'd1) ? scl[SCL_WORD_HI:SCL_WORD_LO] : set - 12'd1;
                        if (strobe && !hit) begin
                            miss <= 1'b1;
                        end
                        if (word_end) begin
                            word_out <= pix_cap;
                            pix      <= 32'd0;
                            valid    <= 1'b1;
                            if (valid && !rdack) begin
                                ovf <= 1'b1;
                            end
                        end else begin
                            pix <= pix_cap;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (setcfg) begin
                ovf  <= 1'b0;
                miss <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cog_vcap.sv
// tb/tb_cog_vcap.sv - directed self-checking bench for cog_vcap
module tb_cog_vcap;

    logic        clk;
    logic        nres;
    logic        setcfg;
    logic        setscl;
    logic [31:0] data;
    logic [31:0] pin_in;
    logic [31:0] palette;
    logic        rdack;
    logic [31:0] word_out;
    logic        valid;
    logic        ovf;
    logic        miss;

    int checks = 0;
    int errors = 0;

    cog_vcap dut (
        .clk_cog  (clk),
        .nres     (nres),
        .setcfg   (setcfg),
        .setscl   (setscl),
        .data     (data),
        .pin_in   (pin_in),
        .palette  (palette),
        .rdack    (rdack),
        .word_out (word_out),
        .valid    (valid),
        .ovf      (ovf),
        .miss     (miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        nres = 1'b0;
        step();
        nres = 1'b1;
        step();
    endtask

    task automatic start(input logic [19:0] s, input logic [31:0] c);
        data   = {12'd0, s};
        setscl = 1'b1;
        step();
        setscl = 1'b0;
        data   = c;
        setcfg = 1'b1;
        step();
        setcfg = 1'b0;
        data   = 32'd0;
    endtask

    task automatic run_cycle16();
        for (int i = 0; i < 16; i++) begin
            pin_in = 32'(i % 4);
            step();
        end
    endtask

    initial begin
        nres    = 1'b0;
        setcfg  = 1'b0;
        setscl  = 1'b0;
        data    = 32'd0;
        pin_in  = 32'd0;
        palette = 32'h0302_0100;
        rdack   = 1'b0;

        #12;
        check("rst_word", word_out, 32'd0);
        check("rst_valid", valid, 0);
        check("rst_ovf", ovf, 0);
        check("rst_miss", miss, 0);
        nres = 1'b1;
        step();

        // 2-bit mode, one pixel per clock, 16-clock word
        start(20'h01010, 32'h3000_00FF);
        for (int i = 0; i < 16; i++) begin
            pin_in = 32'(i % 4);
            if (i == 15) check("t1_valid_early", valid, 0);
            step();
        end
        check("t1_word", word_out, 32'hE4E4_E4E4);
        check("t1_valid", valid, 1);
        check("t1_ovf", ovf, 0);
        check("t1_miss", miss, 0);

        rdack = 1'b1;
        step();
        rdack = 1'b0;
        check("t1_rdack_valid", valid, 0);
        check("t1_rdack_word", word_out, 32'hE4E4_E4E4);

        repeat (3) step();
        data   = 32'd0;
        setcfg = 1'b1;
        step();
        setcfg = 1'b0;
        repeat (40) step();
        check("t1_idle_valid", valid, 0);
        check("t1_idle_word", word_out, 32'hE4E4_E4E4);

        // 1-bit mode, two clocks per pixel, 64-clock word
        pulse_reset();
        start(20'h02040, 32'h2000_00FF);
        for (int k = 1; k <= 64; k++) begin
            pin_in = 32'(((k - 1) / 2) % 2);
            if (k == 64) check("t2_valid_early", valid, 0);
            step();
        end
        check("t2_word", word_out, 32'hAAAA_AAAA);
        check("t2_valid", valid, 1);

        // second unread word -> overflow
        for (int k = 1; k <= 64; k++) begin
            pin_in = 32'd1;
            step();
        end
        check("t3_word", word_out, 32'hFFFF_FFFF);
        check("t3_valid", valid, 1);
        check("t3_ovf", ovf, 1);
        data   = 32'h2000_00FF;
        setcfg = 1'b1;
        step();
        setcfg = 1'b0;
        data   = 32'd0;
        check("t3_ovf_clear", ovf, 0);
        check("t3_valid_kept", valid, 1);

        // rdack on the exact word-end edge
        pulse_reset();
        start(20'h01010, 32'h3000_00FF);
        run_cycle16();
        check("t4_first_word", word_out, 32'hE4E4_E4E4);
        for (int i = 0; i < 16; i++) begin
            pin_in = 32'd3;
            rdack  = (i == 15);
            step();
        end
        rdack = 1'b0;
        check("t4_valid", valid, 1);
        check("t4_ovf", ovf, 0);
        check("t4_word", word_out, 32'hFFFF_FFFF);

        // unmatched sample -> miss, index 0
        pulse_reset();
        start(20'h01010, 32'h3000_00FF);
        for (int i = 0; i < 16; i++) begin
            pin_in = 32'h0000_0055;
            step();
        end
        check("t5_miss", miss, 1);
        check("t5_word", word_out, 32'd0);
        check("t5_valid", valid, 1);
        data   = 32'd0;
        setcfg = 1'b1;
        step();
        setcfg = 1'b0;
        check("t5_miss_clear", miss, 0);
        check("t5_valid_kept", valid, 1);

        // mask 0F, byte group 1, palette entry 1 = F5
        pulse_reset();
        palette = 32'h0302_F500;
        start(20'h01010, 32'h3000_020F);
        for (int i = 0; i < 16; i++) begin
            pin_in = 32'h1234_A566;
            step();
        end
        check("t5b_word", word_out, 32'h5555_5555);
        check("t5b_miss", miss, 0);
        check("t5b_valid", valid, 1);

        // asynchronous reset mid-word, then clean restart
        pulse_reset();
        palette = 32'h0302_0100;
        start(20'h01010, 32'h3000_00FF);
        run_cycle16();
        check("t6_pre_word", word_out, 32'hE4E4_E4E4);
        for (int i = 0; i < 8; i++) begin
            pin_in = 32'(i % 4);
            step();
        end
        #2;
        nres = 1'b0;
        #1;
        check("t6_async_word", word_out, 32'd0);
        check("t6_async_valid", valid, 0);
        check("t6_async_ovf", ovf, 0);
        check("t6_async_miss", miss, 0);
        @(posedge clk);
        #1;
        nres = 1'b1;
        step();
        start(20'h01010, 32'h3000_00FF);
        for (int i = 0; i < 16; i++) begin
            pin_in = 32'(i % 4);
            if (i == 15) check("t6_valid_early", valid, 0);
            step();
        end
        check("t6_word", word_out, 32'hE4E4_E4E4);
        check("t6_valid", valid, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
